beat_sequencer: RTL and testbench
=================================

# beat_sequencer

Consumes the tempo tick produced by the timing divider and turns it into the scrolling note field of the game. Counts in before the song, then streams one pattern row per beat from the synchronous pattern ROM into the top of an 8-row × 4-lane shift grid. The bottom row is presented to the hit-judgement logic, and the whole grid goes to the display driver.

## Interface
- ADDR_W, 6: pattern ROM address width; maximum song length is 2^ADDR_W−1 steps.
- LANES, 4: number of note lanes (one bit per lane per row).
- ROWS, 8: number of visible grid rows; row 0 is the hit row.
- COUNTDOWN, 3: number of count-in beats, range 1..3.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- tick  in  1  divider output. May stay high for several cycles; only its rising edge counts.
- start  in  1  one-cycle request; honoured only in IDLE or DONE.
- pause  in  1  level; while high, tick edges are discarded.
- song_len  in  ADDR_W  number of pattern steps; sampled on an accepted start.
- rom_addr  out  ADDR_W  pattern ROM address (registered).
- rom_data  in  LANES  ROM row; valid one cycle after rom_addr changes.
- field  out  ROWS*LANES  grid; bits [LANES-1:0] are row 0.
- hit_row  out  LANES  equals field[LANES-1:0].
- step_strobe  out  1  one-cycle pulse after each grid shift.
- countdown  out  2  remaining count-in beats; 0 outside COUNT.
- busy  out  1  high in COUNT and PLAY.
- done  out  1  high in DONE.

## Operation
**Beat detection**
- A beat is a rising edge of tick: tick=1 and tick_q=0.
- tick_q resets to 1, so a tick held high through reset release gives no beat.
- tick_q is updated every cycle, including while paused. Releasing pause therefore never produces a stale beat.

**States**
- IDLE. On start: latch song_len, clear field, set step_idx=0 and rom_addr=0, load countdown=COUNTDOWN, go to COUNT.
- COUNT. Each beat decrements countdown.
  - A beat at countdown=1 goes to PLAY, or to DONE if the latched song_len=0.
  - That transition beat does not shift the grid.
- PLAY. Each beat:
  - shifts the grid: row r takes row r+1, and row 0 is discarded;
  - loads the top row with rom_data if step_idx < song_len, otherwise with 0;
  - increments step_idx and sets rom_addr = step_idx+1, saturating at song_len;
  - pulses step_strobe.
- End of PLAY. After song_len+ROWS beats, the last note has left row 0. Go to DONE; field is all zero at that point.
- DONE. done=1 and field is held. start behaves as in IDLE.

**Other rules**
- pause high in COUNT or PLAY: beats are ignored and all state is held. pause has no effect in IDLE or DONE.
- start outside IDLE or DONE is ignored.
- step_idx is ADDR_W+1 bits wide, so song_len+ROWS never wraps.
- rst at any time returns to the reset state immediately. There is no partial recovery.

## Timing
- Reset values: rom_addr=0, field=0, hit_row=0, step_strobe=0, countdown=0, busy=0, done=0, state=IDLE, tick_q=1.
- start accepted in cycle t: COUNT state, busy=1 and countdown=COUNTDOWN are all visible in cycle t+1.
- Beat detected in cycle t: the new field, rom_addr and state are visible in cycle t+1, and step_strobe is high for cycle t+1 only.
- Beats are at least 2 cycles apart, so rom_data for the new rom_addr is always valid by the next beat. No ROM stall logic is needed.
- A beat and start in the same cycle: in IDLE/DONE, start wins and the beat is discarded. Otherwise start is ignored and the beat is processed.
- A beat and pause in the same cycle: the beat is discarded.

## Structure
- Shared package `timing_pkg`:
  - state enum {IDLE, COUNT, PLAY, DONE};
  - LANES and ROWS defaults;
  - a COUNTDOWN_MAX=3 constant.
- Sub-module `tick_edge`: rising-edge detector with a reset-to-1 register. It is reusable by other consumers of the divider.

## Test plan
- Reset with tick held high, release rst, hold tick high for 10 cycles → no step_strobe, countdown=0, all outputs at reset values.
- COUNTDOWN=3, song_len=2, ROM[0]=4'b0001, ROM[1]=4'b1000, then start and 13 beats:
  - countdown reads 3, 2, 1, 0;
  - 0001 enters row 7 at PLAY beat 1 and reaches hit_row at beat 8;
  - 1000 reaches hit_row at beat 9;
  - done=1 after beat 10 of PLAY, with field=0.
- tick held high for 5 cycles per beat → exactly one shift per high period; step_strobe width is exactly 1 cycle.
- In PLAY, pause=1 across 3 tick edges, then release with tick already high → field and rom_addr unchanged, no shift until the next true rising edge.
- song_len=0, start, 3 beats → COUNT goes directly to DONE; field stays 0 and there is no step_strobe.
- rst asserted mid-PLAY with a non-zero field → all outputs zero asynchronously. A later start restarts from rom_addr=0.

Source files
------------

// File: rtl/timing_pkg.sv
// Shared types and defaults for consumers of the tempo divider.
// Holds the sequencer state encoding and the default grid geometry.
package timing_pkg;

  typedef enum logic [1:0] {IDLE, COUNT, PLAY, DONE} state_t;

  localparam int ADDR_W_DEF    = 6;
  localparam int LANES_DEF     = 4;
  localparam int ROWS_DEF      = 8;
  localparam int COUNTDOWN_MAX = 3;

endpackage

// File: rtl/beat_sequencer_if.sv
// Tick/control inputs, pattern ROM port and note-field outputs of the beat sequencer.
// The slave modport is the sequencer's view; master is the environment's view.
interface beat_sequencer_if
  import timing_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int ROWS   = ROWS_DEF
);
  logic                   tick;
  logic                   start;
  logic                   pause;
  logic [ADDR_W-1:0]      song_len;
  logic [ADDR_W-1:0]      rom_addr;
  logic [LANES-1:0]       rom_data;
  logic [ROWS*LANES-1:0]  field;
  logic [LANES-1:0]       hit_row;
  logic                   step_strobe;
  logic [1:0]             countdown;
  logic                   busy;
  logic                   done;

  modport master (
    output tick, start, pause, song_len, rom_data,
    input  rom_addr, field, hit_row, step_strobe, countdown, busy, done
  );

  modport slave (
    input  tick, start, pause, song_len, rom_data,
    output rom_addr, field, hit_row, step_strobe, countdown, busy, done
  );
endinterface

// File: rtl/tick_edge.sv
// Rising-edge detector for the divider tick. The history register resets high
// so a tick already asserted when reset releases does not count as an edge.
module tick_edge (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  output logic rise
);
  logic tick_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_q <= 1'b1;
    else     tick_q <= tick;
  end

  assign rise = tick & ~tick_q;
endmodule

// File: rtl/beat_sequencer.sv
// Beat sequencer: count-in, then one ROM pattern row per beat shifted into the
// top of the note grid; row 0 is the hit row presented for judgement.
module beat_sequencer
  import timing_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int LANES     = LANES_DEF,
  parameter int ROWS      = ROWS_DEF,
  parameter int COUNTDOWN = COUNTDOWN_MAX
) (
  input logic             clk,
  input logic             rst,
  beat_sequencer_if.slave bus
);
  localparam int SW = ADDR_W + 1;

  state_t                state_reg;
  logic [ROWS*LANES-1:0] field_reg;
  logic [ROWS*LANES-1:0] field_shift;
  logic [SW-1:0]         step_idx_reg;
  logic [SW-1:0]         step_next;
  logic [SW-1:0]         len_ext;
  logic [ADDR_W-1:0]     len_reg;
  logic [ADDR_W-1:0]     rom_addr_reg;
  logic [ADDR_W-1:0]     rom_addr_next;
  logic [1:0]            countdown_reg;
  logic                  strobe_reg;
  logic                  beat;
  logic [LANES-1:0]      top_row;

  tick_edge u_tick_edge (
    .clk  (clk),
    .rst  (rst),
    .tick (bus.tick),
    .rise (beat)
  );

  assign len_ext       = {1'b0, len_reg};
  assign step_next     = step_idx_reg + SW'(1);
  assign top_row       = (step_idx_reg < len_ext) ? bus.rom_data : '0;
  assign rom_addr_next = (step_next > len_ext) ? len_reg : step_next[ADDR_W-1:0];

  // Each row takes the one above it; the top row takes the new pattern row.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_shift
    if (gi == ROWS - 1) begin : g_top
      assign field_shift[gi*LANES +: LANES] = top_row;
    end else begin : g_row
      assign field_shift[gi*LANES +: LANES] = field_reg[(gi+1)*LANES +: LANES];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      field_reg     <= '0;
      step_idx_reg  <= '0;
      len_reg       <= '0;
      rom_addr_reg  <= '0;
      countdown_reg <= '0;
      strobe_reg    <= 1'b0;
    end else begin
      strobe_reg <= 1'b0;
      if (bus.start && (state_reg == IDLE || state_reg == DONE)) begin
        len_reg       <= bus.song_len;
        field_reg     <= '0;
        step_idx_reg  <= '0;
        rom_addr_reg  <= '0;
        countdown_reg <= 2'(COUNTDOWN);
        state_reg     <= COUNT;
      end else if (beat && !bus.pause) begin
        case (state_reg)
          COUNT: begin
            if (countdown_reg == 2'd1) begin
              countdown_reg <= '0;
              state_reg     <= (len_reg == '0) ? DONE : PLAY;
            end else begin
              countdown_reg <= countdown_reg - 2'd1;
            end
          end
          PLAY: begin
            field_reg    <= field_shift;
            step_idx_reg <= step_next;
            rom_addr_reg <= rom_addr_next;
            strobe_reg   <= 1'b1;
            // The last note leaves row 0 ROWS beats after the final step loads.
            if (step_next == len_ext + SW'(ROWS)) state_reg <= DONE;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rom_addr    = rom_addr_reg;
  assign bus.field       = field_reg;
  assign bus.hit_row     = field_reg[LANES-1:0];
  assign bus.step_strobe = strobe_reg;
  assign bus.countdown   = countdown_reg;
  assign bus.busy        = (state_reg == COUNT) || (state_reg == PLAY);
  assign bus.done        = (state_reg == DONE);
endmodule

// File: tb/tb_beat_sequencer.sv
// Randomized scoreboard bench for beat_sequencer against a song-position model:
// row r after play beat k holds song step k-(ROWS-r), when that step exists.
module tb_beat_sequencer;
  localparam int AW = 6;
  localparam int LN = 4;
  localparam int RW = 8;
  localparam int CD = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  beat_sequencer_if #(.ADDR_W(AW), .LANES(LN), .ROWS(RW)) bus ();

  beat_sequencer #(.ADDR_W(AW), .LANES(LN), .ROWS(RW), .COUNTDOWN(CD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [LN-1:0] rom [64];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] field;
    logic [5:0]  addr;
    int          k;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Model: phase 0 idle, 1 count-in, 2 playing, 3 done
  int ph = 0;
  int m_cnt = 0;
  int m_k = 0;
  int m_len = 0;

  function automatic logic [31:0] exp_field(int k);
    logic [31:0] f;
    int s;
    f = '0;
    for (int r = 0; r < RW; r++) begin
      s = k - (RW - r);
      if (s >= 0 && s < m_len) f[r*LN +: LN] = rom[s];
    end
    return f;
  endfunction

  function automatic logic [5:0] exp_addr(int k);
    return 6'((k < m_len) ? k : m_len);
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_beat();
    exp_t e;
    if (bus.pause) return;
    case (ph)
      1: begin
        m_cnt--;
        if (m_cnt == 0) ph = (m_len == 0) ? 3 : 2;
      end
      2: begin
        m_k++;
        e.field = exp_field(m_k);
        e.addr  = exp_addr(m_k);
        e.k     = m_k;
        sb.push_back(e);
        if (m_k == m_len + RW) ph = 3;
      end
      default: ;
    endcase
  endtask

  task automatic check_status();
    chk("countdown", 32'(bus.countdown), (ph == 1) ? m_cnt : 0);
    chk("busy", 32'(bus.busy), (ph == 1 || ph == 2) ? 1 : 0);
    chk("done", 32'(bus.done), (ph == 3) ? 1 : 0);
  endtask

  task automatic do_beat(int hi, int lo);
    bus.tick = 1'b1;
    model_beat();
    step();
    check_status();
    repeat (hi - 1) step();
    bus.tick = 1'b0;
    repeat (lo) step();
  endtask

  task automatic do_start(int len);
    bus.song_len = 6'(len);
    bus.start    = 1'b1;
    if (ph == 0 || ph == 3) begin
      m_len = len;
      ph    = 1;
      m_cnt = CD;
      m_k   = 0;
    end
    step();
    bus.start = 1'b0;
    check_status();
    chk("start_addr", 32'(bus.rom_addr), 32'(exp_addr(m_k)));
    chk("start_field", bus.field, exp_field(m_k));
    $display("[TB] start len=%0d phase=%0d countdown=%0d", len, ph, bus.countdown);
  endtask

  task automatic run_to_done(int hi, int lo);
    int guard;
    guard = 0;
    while (ph != 3 && guard < 80) begin
      do_beat(hi, lo);
      guard++;
    end
    chk("done_bound", ph, 3);
    chk("end_field", bus.field, 32'h0);
    chk("end_done", 32'(bus.done), 1);
  endtask

  // Monitor: every grid shift is matched against the next scoreboard entry.
  logic prev_strobe = 1'b0;
  always @(negedge clk) begin
    if (bus.step_strobe) begin
      chk("strobe_width", 32'(prev_strobe), 0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: got strobe with field %h expected none", bus.field);
      end else begin
        mon_e = sb.pop_front();
        chk("field", bus.field, mon_e.field);
        chk("hit_row", 32'(bus.hit_row), 32'(mon_e.field[3:0]));
        chk("rom_addr", 32'(bus.rom_addr), 32'(mon_e.addr));
        $display("[TB] beat %0d field=%h hit=%b addr=%0d", mon_e.k, bus.field, bus.hit_row, bus.rom_addr);
      end
    end
    prev_strobe = bus.step_strobe;
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 4'($urandom);
    rst          = 1'b1;
    bus.tick     = 1'b1;
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    bus.song_len = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Tick held high across reset release
    repeat (10) step();
    check_status();
    chk("rst_field", bus.field, 32'h0);
    chk("rst_hit", 32'(bus.hit_row), 0);
    chk("rst_addr", 32'(bus.rom_addr), 0);
    chk("rst_strobe", 32'(bus.step_strobe), 0);
    bus.tick = 1'b0;
    step();

    // Two-step song, 5-cycle-high ticks
    rom[0] = 4'b0001;
    rom[1] = 4'b1000;
    do_start(2);
    run_to_done(5, 2);

    // Pause across three edges, release with tick already high
    for (int i = 0; i < 4; i++) rom[i] = 4'($urandom_range(1, 15));
    do_start(4);
    repeat (5) do_beat(2, 2);
    bus.pause = 1'b1;
    repeat (3) do_beat(2, 2);
    bus.tick = 1'b1;
    step();
    bus.pause = 1'b0;
    repeat (3) step();
    chk("pause_field", bus.field, exp_field(m_k));
    chk("pause_addr", 32'(bus.rom_addr), 32'(exp_addr(m_k)));
    bus.tick = 1'b0;
    step();
    run_to_done(2, 2);

    // Empty song goes straight from count-in to done
    do_start(0);
    run_to_done(3, 1);

    // Asynchronous reset in the middle of play
    for (int i = 0; i < 5; i++) rom[i] = 4'hF;
    do_start(5);
    repeat (6) do_beat(1, 2);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_field", bus.field, 32'h0);
    chk("arst_addr", 32'(bus.rom_addr), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_count", 32'(bus.countdown), 0);
    chk("arst_done", 32'(bus.done), 0);
    sb.delete();
    ph    = 0;
    m_k   = 0;
    m_len = 0;
    step();
    rst = 1'b0;
    step();
    do_start(3);
    run_to_done(2, 1);

    // Randomized songs with random tick shape, pauses and ignored starts
    for (int s = 0; s < 6; s++) begin
      int len;
      int guard;
      len = $urandom_range(0, 12);
      for (int i = 0; i < 64; i++) rom[i] = 4'($urandom);
      do_start(len);
      guard = 0;
      while (ph != 3 && guard < 120) begin
        if ($urandom_range(0, 7) == 0) do_start($urandom_range(0, 20));
        bus.pause = ($urandom_range(0, 4) == 0);
        do_beat($urandom_range(1, 4), $urandom_range(1, 3));
        bus.pause = 1'b0;
        guard++;
      end
      chk("rand_done_bound", ph, 3);
      chk("rand_end_field", bus.field, 32'h0);
    end

    repeat (3) step();
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
